// File: rtl/vector_checker.sv
// Memory-driven test-vector sequencer: applies stored stimulus to a device,
// compares its masked response after a settle time, and tallies failures.
module vector_checker #(
  parameter int unsigned IN_W   = 2,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 11,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned ENT_W = IN_W + 2 * OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [ENT_W-1:0] ld_data,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tests,
  input  logic             abort,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] cur_index
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [IN_W-1:0]  r_dut_in, w_dut_in_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_err_pulse, w_err_pulse_nxt;
  logic [CNT_W-1:0] r_err_count, w_err_count_nxt;
  logic [CNT_W-1:0] r_first_err_idx, w_first_err_idx_nxt;
  logic             r_first_err_valid, w_first_err_valid_nxt;
  logic [CNT_W-1:0] r_cur_index, w_cur_index_nxt;
  logic [CNT_W-1:0] r_last, w_last_nxt;
  logic [SW-1:0]    r_settle, w_settle_nxt;

  logic [ENT_W-1:0] w_entry;
  logic [IN_W-1:0]  w_stim;
  logic [OUT_W-1:0] w_exp;
  logic [OUT_W-1:0] w_mask;
  logic             w_fail;
  logic             w_ld_ok;
  logic [31:0]      w_run_len;
  logic [CNT_W-1:0] w_err_count_inc;

  assign w_ld_ok         = ld_en && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_entry         = r_mem[AW'(r_cur_index)];
  assign w_stim          = w_entry[ENT_W-1 -: IN_W];
  assign w_exp           = w_entry[2*OUT_W-1 -: OUT_W];
  assign w_mask          = w_entry[OUT_W-1:0];
  assign w_fail          = |((dut_out ^ w_exp) & w_mask);
  assign w_run_len       = (32'(num_tests) > 32'(DEPTH)) ? 32'(DEPTH) : 32'(num_tests);
  assign w_err_count_inc = (&r_err_count) ? r_err_count : r_err_count + CNT_W'(1);

  // Vector memory: written only while no run is active.
  always_ff @(posedge clk) begin
    if (w_ld_ok) r_mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= S_IDLE;
      r_dut_in          <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_pulse       <= 1'b0;
      r_err_count       <= '0;
      r_first_err_idx   <= '0;
      r_first_err_valid <= 1'b0;
      r_cur_index       <= '0;
      r_last            <= '0;
      r_settle          <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_dut_in          <= w_dut_in_nxt;
      r_busy            <= w_busy_nxt;
      r_done            <= w_done_nxt;
      r_pass            <= w_pass_nxt;
      r_err_pulse       <= w_err_pulse_nxt;
      r_err_count       <= w_err_count_nxt;
      r_first_err_idx   <= w_first_err_idx_nxt;
      r_first_err_valid <= w_first_err_valid_nxt;
      r_cur_index       <= w_cur_index_nxt;
      r_last            <= w_last_nxt;
      r_settle          <= w_settle_nxt;
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    w_dut_in_nxt          = r_dut_in;
    w_done_nxt            = r_done;
    w_pass_nxt            = r_pass;
    w_err_pulse_nxt       = 1'b0;
    w_err_count_nxt       = r_err_count;
    w_first_err_idx_nxt   = r_first_err_idx;
    w_first_err_valid_nxt = r_first_err_valid;
    w_cur_index_nxt       = r_cur_index;
    w_last_nxt            = r_last;
    w_settle_nxt          = r_settle;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_err_count_nxt       = '0;
          w_first_err_idx_nxt   = '0;
          w_first_err_valid_nxt = 1'b0;
          w_cur_index_nxt       = '0;
          w_last_nxt            = CNT_W'(w_run_len - 32'd1);
          // An empty run completes immediately and trivially passes.
          if (w_run_len == 32'd0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_APPLY;
            w_done_nxt  = 1'b0;
            w_pass_nxt  = 1'b0;
          end
        end
      end
      default: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end else begin
          case (r_state)
            S_APPLY: begin
              w_dut_in_nxt = w_stim;
              w_settle_nxt = '0;
              w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
              if (r_settle == SW'(SETTLE - 1)) w_state_nxt = S_CHECK;
              else                             w_settle_nxt = r_settle + SW'(1);
            end
            S_CHECK: begin
              if (w_fail) begin
                w_err_pulse_nxt = 1'b1;
                w_err_count_nxt = w_err_count_inc;
                if (!r_first_err_valid) begin
                  w_first_err_idx_nxt   = r_cur_index;
                  w_first_err_valid_nxt = 1'b1;
                end
              end
              if (r_cur_index == r_last) begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
                w_pass_nxt  = !w_fail && (r_err_count == '0);
              end else begin
                w_cur_index_nxt = r_cur_index + CNT_W'(1);
                w_state_nxt     = S_APPLY;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_APPLY) || (w_state_nxt == S_WAIT) ||
                 (w_state_nxt == S_CHECK);
  end

  assign dut_in          = r_dut_in;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_pulse       = r_err_pulse;
  assign err_count       = r_err_count;
  assign first_err_idx   = r_first_err_idx;
  assign first_err_valid = r_first_err_valid;
  assign cur_index       = r_cur_index;

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: run-level reference model checked every cycle,
// plus literal expectations for the canonical NAND, abort and reset scenarios.
module tb_vector_checker;

  localparam int unsigned IN_W   = 2;
  localparam int unsigned OUT_W  = 1;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned SETTLE = 1;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned ENT_W  = IN_W + 2 * OUT_W;
  localparam int          P      = SETTLE + 2;

  typedef struct packed {
    logic [IN_W-1:0]  dut_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic             pulse;
    logic [CNT_W-1:0] ec;
    logic [CNT_W-1:0] fidx;
    logic             fval;
    logic [CNT_W-1:0] cur;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [ENT_W-1:0] ld_data;
  logic             start;
  logic [CNT_W-1:0] num_tests;
  logic             abort;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy, done, pass, err_pulse, first_err_valid;
  logic [CNT_W-1:0] err_count, first_err_idx, cur_index;

  logic [OUT_W-1:0] dev_tt [2**IN_W];
  assign dut_out = dev_tt[dut_in];

  vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .num_tests(num_tests), .abort(abort), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_valid(first_err_valid), .cur_index(cur_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Model state describing the current run.
  logic [ENT_W-1:0] mem_m [DEPTH];
  logic [IN_W-1:0]  m_stim [DEPTH];
  bit               m_fail [DEPTH];
  int               m_s = 0;
  int               m_n = 0;
  int               m_abort = -1;
  bit               m_reset = 1'b1;
  exp_t             m_pre = '0;
  int               first_done = -1;
  int               pulses = 0;
  bit               chk_en = 1'b0;

  function automatic exp_t core(int k);
    exp_t e;
    int v, ph, nf, lim;
    bit fin;
    e = '0;
    if (m_n == 0) begin
      e.dut_in = m_pre.dut_in;
      e.done   = 1'b1;
      e.pass   = 1'b1;
      return e;
    end
    fin = (k >= m_n * P);
    v   = fin ? m_n : k / P;
    ph  = fin ? 0 : k % P;
    lim = v;
    nf  = 0;
    for (int i = 0; i < lim; i++) begin
      if (m_fail[i]) begin
        if (!e.fval) begin
          e.fval = 1'b1;
          e.fidx = CNT_W'(i);
        end
        nf++;
      end
    end
    e.ec = CNT_W'(nf);
    if (fin) begin
      e.done   = 1'b1;
      e.pass   = (nf == 0);
      e.cur    = CNT_W'(m_n - 1);
      e.dut_in = m_stim[m_n-1];
      e.pulse  = (k == m_n * P) && m_fail[m_n-1];
    end else begin
      e.busy   = 1'b1;
      e.cur    = CNT_W'(v);
      e.pulse  = (v > 0) && (ph == 0) && m_fail[v-1];
      if (ph == 0) e.dut_in = (v > 0) ? m_stim[v-1] : m_pre.dut_in;
      else         e.dut_in = m_stim[v];
    end
    return e;
  endfunction

  function automatic exp_t model_at(int c);
    exp_t e;
    int k;
    if (m_reset) return '0;
    k = c - m_s - 1;
    if (k < 0) return m_pre;
    if (m_abort >= 0 && c > m_abort) begin
      e = core(m_abort - m_s - 1);
      if (e.busy) begin
        e.busy  = 1'b0;
        e.done  = 1'b0;
        e.pass  = 1'b0;
        e.pulse = 1'b0;
        return e;
      end
    end
    return core(k);
  endfunction

  task automatic chk_val(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", nm, a, e, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the run model.
  always @(negedge clk) begin
    exp_t e, a;
    if (chk_en) begin
      e = model_at(cyc);
      a.dut_in = dut_in; a.busy = busy; a.done = done; a.pass = pass; a.pulse = err_pulse;
      a.ec = err_count; a.fidx = first_err_idx; a.fval = first_err_valid; a.cur = cur_index;
      n_chk++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_state cyc=%0d got in=%h busy=%b done=%b pass=%b pulse=%b ec=%0d fidx=%0d fval=%b cur=%0d expected in=%h busy=%b done=%b pass=%b pulse=%b ec=%0d fidx=%0d fval=%b cur=%0d",
                 cyc, a.dut_in, a.busy, a.done, a.pass, a.pulse, a.ec, a.fidx, a.fval, a.cur,
                 e.dut_in, e.busy, e.done, e.pass, e.pulse, e.ec, e.fidx, e.fval, e.cur);
      end
      if (!m_reset && cyc > m_s) begin
        if (done === 1'b1 && first_done < 0) first_done = cyc;
        if (err_pulse === 1'b1) pulses++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [ENT_W-1:0] d);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
    mem_m[a] = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic set_tt(input logic [3:0] v);
    for (int i = 0; i < 4; i++) dev_tt[i] = v[i];
  endtask

  task automatic start_run(input int n);
    logic [ENT_W-1:0] ent;
    m_pre = model_at(cyc);
    m_s = cyc;
    m_n = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    m_abort = -1;
    m_reset = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent = mem_m[i];
      m_stim[i] = ent[ENT_W-1 -: IN_W];
      m_fail[i] = |((dev_tt[m_stim[i]] ^ ent[2*OUT_W-1 -: OUT_W]) & ent[OUT_W-1:0]);
    end
    first_done = -1;
    pulses = 0;
    start = 1'b1; num_tests = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run();
    while (cyc < m_s + m_n * P + 4) tick();
  endtask

  task automatic do_run(input int n);
    start_run(n);
    finish_run();
  endtask

  task automatic load_nand();
    load(0, 4'b0011); load(1, 4'b0111); load(2, 4'b1011); load(3, 4'b1101);
  endtask

  initial begin
    int n, k;
    reset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; num_tests = '0; abort = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
    set_tt(4'b0000);
    chk_en = 1'b1;
    tick(); tick();
    chk_val("reset_busy", 32'(busy), 0);
    chk_val("reset_cur_index", 32'(cur_index), 0);
    reset = 1'b1;
    tick();

    // NAND device answering correctly.
    load_nand();
    set_tt(4'b0111);
    do_run(4);
    chk_val("nand_done_latency", 32'(first_done - m_s), 13);
    chk_val("nand_pass", 32'(pass), 1);
    chk_val("nand_err_count", 32'(err_count), 0);

    // Device stuck at 1.
    set_tt(4'b1111);
    do_run(4);
    chk_val("stuck_pulses", 32'(pulses), 1);
    chk_val("stuck_err_count", 32'(err_count), 1);
    chk_val("stuck_first_idx", 32'(first_err_idx), 3);
    chk_val("stuck_pass", 32'(pass), 0);

    // Vector 3 masked off.
    load(3, 4'b1100);
    do_run(4);
    chk_val("masked_pass", 32'(pass), 1);
    chk_val("masked_pulses", 32'(pulses), 0);

    // Empty run.
    do_run(0);
    chk_val("zero_latency", 32'(first_done - m_s), 1);
    chk_val("zero_dut_in", 32'(dut_in), 3);
    chk_val("zero_pass", 32'(pass), 1);

    // Oversized count clamps to memory depth.
    for (int i = 0; i < int'(DEPTH); i++) load(i, ENT_W'($urandom));
    for (int i = 0; i < 4; i++) dev_tt[i] = OUT_W'($urandom);
    do_run(40);
    chk_val("clamp_latency", 32'(first_done - m_s), 32 * P + 1);
    chk_val("clamp_cur_index", 32'(cur_index), 31);

    // Abort during the settle phase of vector 1, then a clean rerun.
    load_nand();
    set_tt(4'b0111);
    start_run(4);
    while (cyc < m_s + 5) tick();
    abort = 1'b1; m_abort = cyc;
    tick();
    abort = 1'b0;
    chk_val("abort_busy", 32'(busy), 0);
    chk_val("abort_done", 32'(done), 0);
    finish_run();
    do_run(4);
    chk_val("rerun_pass", 32'(pass), 1);
    chk_val("rerun_err_count", 32'(err_count), 0);

    // Asynchronous reset in the check phase of vector 2.
    start_run(4);
    while (cyc < m_s + 9) tick();
    #2;
    reset = 1'b0; m_reset = 1'b1;
    #1;
    chk_val("async_rst_busy", 32'(busy), 0);
    chk_val("async_rst_cur", 32'(cur_index), 0);
    chk_val("async_rst_dut_in", 32'(dut_in), 0);
    chk_val("async_rst_done_pass", 32'({done, pass, first_err_valid}), 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Load and start while busy must be ignored.
    start_run(4);
    tick();
    ld_en = 1'b1; ld_addr = AW'(3); ld_data = 4'b0001;
    start = 1'b1; num_tests = CNT_W'(2);
    tick();
    ld_en = 1'b0; start = 1'b0;
    finish_run();
    chk_val("busy_ignore_latency", 32'(first_done - m_s), 13);
    chk_val("busy_ignore_pass", 32'(pass), 1);
    do_run(4);
    chk_val("mem_untouched_pass", 32'(pass), 1);

    // Randomized runs with occasional aborts (some landing after completion).
    for (int it = 0; it < 14; it++) begin
      for (int j = 0; j < 4; j++) load($urandom_range(0, DEPTH - 1), ENT_W'($urandom));
      for (int i = 0; i < 4; i++) dev_tt[i] = OUT_W'($urandom);
      n = $urandom_range(0, 40);
      start_run(n);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, m_n * P + 2);
        while (cyc < m_s + 1 + k) tick();
        abort = 1'b1; m_abort = cyc;
        tick();
        abort = 1'b0;
      end
      finish_run();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 Parameter IN_W, default 2, width of stimulus driven to the device under check.
REQ-002 Parameter OUT_W, default 1, width of the device response compared per vector.
REQ-003 Parameter DEPTH, default 32, number of vector memory entries (power of two, ≥2).
REQ-004 Parameter SETTLE, default 1, settle cycles between apply and compare (≥1).
REQ-005 Parameter CNT_W, default 11, width of index, test-count and error counters.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 ld_en  input  1  write one vector entry this cycle.
REQ-009 ld_addr  input  log2(DEPTH)  entry address for ld_en.
REQ-010 ld_data  input  IN_W+2*OUT_W  entry {stim, expected, mask}, stim in MSBs.
REQ-011 start  input  1  one-cycle pulse launching a run.
REQ-012 num_tests  input  CNT_W  vectors to run, sampled on accepted start.
REQ-013 abort  input  1  terminate a run in progress.
REQ-014 dut_in  output  IN_W  stimulus to device.
REQ-015 dut_out  input  OUT_W  device response.
REQ-016 busy  output  1  run in progress.
REQ-017 done  output  1  run completed; held until next accepted start.
REQ-018 pass  output  1  valid while done; 1 when err_count is zero.
REQ-019 err_pulse  output  1  one-cycle strobe per failing vector.
REQ-020 err_count  output  CNT_W  failing vectors this run, saturating.
REQ-021 first_err_idx  output  CNT_W  index of first failing vector; valid when first_err_valid.
REQ-022 first_err_valid  output  1  at least one failure captured this run.
REQ-023 cur_index  output  CNT_W  index of vector currently applied.

Function
REQ-024 States SHALL be IDLE, APPLY, WAIT, CHECK, DONE.
REQ-025 ld_en SHALL write memory only in IDLE or DONE; ignored while busy.
REQ-026 start in IDLE or DONE: clears err_count, first_err_*, cur_index, done, pass; latches min(num_tests, DEPTH); enters APPLY, or DONE with pass=1 if num_tests=0.
REQ-027 start while busy SHALL be ignored.
REQ-028 APPLY: dut_in <= stim of entry cur_index; next state WAIT.
REQ-029 WAIT: hold dut_in for exactly SETTLE cycles, then CHECK.
REQ-030 CHECK: failure iff ((dut_out ^ expected) & mask) != 0; mask bit 0 = don't-care.
REQ-031 On failure: err_pulse=1 for that cycle; err_count+1, saturating at all-ones; if first_err_valid=0, capture cur_index and set first_err_valid.
REQ-032 CHECK then: if cur_index = latched count-1 go DONE, else cur_index+1 and APPLY.
REQ-033 Per-vector latency SHALL be SETTLE+2 cycles; run of N vectors reaches DONE N*(SETTLE+2)+1 cycles after start.
REQ-034 DONE: done=1, pass=(err_count==0), busy=0; dut_in holds last stimulus.
REQ-035 abort while busy: return to IDLE next cycle, done=0, pass=0, counters hold; abort ignored when not busy.
REQ-036 busy SHALL be 1 in APPLY, WAIT, CHECK only.

Reset
REQ-037 reset low SHALL immediately force IDLE and zero dut_in, busy, done, pass, err_pulse, err_count, first_err_idx, first_err_valid, cur_index.
REQ-038 Reset mid-run SHALL discard the run; memory contents need not be cleared.

Verification
REQ-039 Load 4 NAND vectors {00,1,1},{01,1,1},{10,1,1},{11,0,1}, correct NAND on dut_out, num_tests=4, SETTLE=1 -> done after 13 cycles, pass=1, err_count=0.
REQ-040 Same vectors, device stuck at 1 -> one err_pulse, err_count=1, first_err_idx=3, pass=0.
REQ-041 Vector 3 mask=0, device stuck at 1 -> pass=1, no err_pulse.
REQ-042 num_tests=0 -> done and pass next cycle, dut_in unchanged; num_tests=40 with DEPTH=32 -> exactly 32 vectors run.
REQ-043 abort during WAIT of vector 1 -> IDLE next cycle, done=0; start again -> counters cleared, full run passes.
REQ-044 reset asserted during CHECK of vector 2 -> all outputs zero asynchronously; ld_en and start while busy -> no memory change, run unaffected.
